conv_intlv_commutator: RTL

CONV_INTLV_COMMUTATOR -- requirements
Module: conv_intlv_commutator

---
 rtl/conv_intlv_commutator.sv | 104 ++++++++++
 1 files changed

// File: rtl/conv_intlv_commutator.sv
// Input commutator of a DVB-style convolutional interleaver: hunts for the sync byte,
// deals accepted bytes round-robin onto the branch delay lines and collects their oldest bytes.
module conv_intlv_commutator #(
  parameter int          NUM_BRANCH = 12,
  parameter int          PKT_LEN    = 204,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter int          MISS_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic [NUM_BRANCH-1:0]   branch_we,
  output logic [7:0]              branch_wdata,
  input  logic [8*NUM_BRANCH-1:0] branch_rdata,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic [3:0]              branch_idx,
  output logic                    sync_lock
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int MW = $clog2(MISS_LIMIT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_nx;
  logic [3:0]      idx_nx;
  logic [CW-1:0]   byte_cnt, cnt_nx;
  logic [MW-1:0]   miss_cnt, miss_nx;
  logic            is_sync;
  logic            wr_nx;
  logic [3:0]      wr_idx;
  logic [7:0]      rd_slice;

  assign is_sync   = (in_data == SYNC_BYTE) || (in_data == ~SYNC_BYTE);
  assign sync_lock = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      branch_idx <= '0;
      byte_cnt   <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nx;
      branch_idx <= idx_nx;
      byte_cnt   <= cnt_nx;
      miss_cnt   <= miss_nx;
    end
  end

  // In HUNT the counters are already zero, so a sync byte takes the ordinary byte-0 path.
  always_comb begin
    state_nx = state;
    idx_nx   = branch_idx;
    cnt_nx   = byte_cnt;
    miss_nx  = miss_cnt;
    wr_nx    = 1'b0;
    if (in_valid && (state == LOCKED || is_sync)) begin
      if (byte_cnt == '0 && !is_sync && (miss_cnt + MW'(1)) == MW'(MISS_LIMIT)) begin
        state_nx = HUNT;
        idx_nx   = '0;
        cnt_nx   = '0;
        miss_nx  = '0;
      end else begin
        wr_nx    = 1'b1;
        state_nx = LOCKED;
        if (byte_cnt == '0)
          miss_nx = is_sync ? '0 : miss_cnt + MW'(1);
        idx_nx = (branch_idx == 4'(NUM_BRANCH - 1)) ? 4'd0 : branch_idx + 4'd1;
        cnt_nx = (byte_cnt == CW'(PKT_LEN - 1)) ? '0 : byte_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    rd_slice = 8'h00;
    for (int k = 0; k < NUM_BRANCH; k++)
      if (wr_idx == 4'(k))
        rd_slice = branch_rdata[8*k +: 8];
  end

  // Branch 0 has no delay line, so its output is the byte being written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_we    <= '0;
      branch_wdata <= 8'h00;
      wr_idx       <= '0;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
    end else begin
      branch_we <= wr_nx ? (NUM_BRANCH'(1) << branch_idx) : '0;
      if (wr_nx) begin
        branch_wdata <= in_data;
        wr_idx       <= branch_idx;
      end
      out_valid <= |branch_we;
      if (|branch_we)
        out_data <= (wr_idx == 4'd0) ? branch_wdata : rd_slice;
    end
  end

endmodule
